// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave with NUM_OPERANDS operand registers and a sequential
// sum / subtract / accumulate engine that folds one operand per cycle.
module axil_multi_adder #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned NUM_OPERANDS = 4
) (
    input  logic                      s0_axi_aclk,
    input  logic                      s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
    input  logic                      s0_axi_awvalid,
    output logic                      s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
    input  logic                      s0_axi_wvalid,
    output logic                      s0_axi_wready,
    output logic [1:0]                s0_axi_bresp,
    output logic                      s0_axi_bvalid,
    input  logic                      s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_araddr,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [DATA_WIDTH-1:0]     s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned CW = $clog2(NUM_OPERANDS + 1);
    localparam int unsigned WW = ADDR_WIDTH - 2;

    localparam logic [WW-1:0] IDX_CTRL   = WW'(0);
    localparam logic [WW-1:0] IDX_STATUS = WW'(1);
    localparam logic [WW-1:0] IDX_RESULT = WW'(2);
    localparam logic [WW-1:0] IDX_COUNT  = WW'(3);

    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // write channel holders
    logic                  r_aw_held;
    logic [WW-1:0]         r_aw_idx;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [SW-1:0]         r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    // read channel
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    // register file
    logic [DATA_WIDTH-1:0] r_operand [NUM_OPERANDS];
    logic [CW-1:0]         r_count;
    logic [1:0]            r_mode;

    // engine
    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_result;
    logic [CW-1:0]         r_k;
    logic [CW-1:0]         r_n;
    logic [1:0]            r_run_mode;
    logic                  r_done;
    logic                  r_carry;

    // decode / datapath wires
    logic [WW-1:0]           w_wr_idx;
    logic [NUM_OPERANDS-1:0] w_wr_op_sel;
    logic                    w_wr_ctrl;
    logic                    w_wr_count;
    logic                    w_wr_err;
    logic                    w_commit;
    logic                    w_wr_ok;
    logic                    w_start;
    logic                    w_busy;
    logic [WW-1:0]           w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_rd_err;
    logic [DATA_WIDTH-1:0]   w_cur_op;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_acc_next;
    logic                    w_carry_step;
    logic                    w_last;
    logic                    w_unused;

    // byte-lane merge of new write data over the current register value
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [SW-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] v;
        v = old_v;
        for (int unsigned b = 0; b < SW; b++) begin
            if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

    // COUNT is always kept in [1, NUM_OPERANDS]
    function automatic logic [CW-1:0] f_clamp(input logic [DATA_WIDTH-1:0] v);
        logic [CW-1:0] c;
        if (v == '0)                               c = CW'(1);
        else if (v > DATA_WIDTH'(NUM_OPERANDS))    c = CW'(NUM_OPERANDS);
        else                                       c = v[CW-1:0];
        return c;
    endfunction

    assign w_busy         = (r_state == S_RUN);
    assign s0_axi_awready = !r_aw_held && !r_bvalid;
    assign s0_axi_wready  = !r_w_held && !r_bvalid;
    assign s0_axi_bvalid  = r_bvalid;
    assign s0_axi_bresp   = r_bresp;
    assign s0_axi_arready = !r_rvalid;
    assign s0_axi_rvalid  = r_rvalid;
    assign s0_axi_rresp   = r_rresp;
    assign s0_axi_rdata   = r_rdata;
    assign w_unused       = ^{s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

    // decode the held write and decide whether it commits, errors or starts the engine
    always_comb begin
        w_wr_idx    = r_aw_idx;
        w_wr_op_sel = '0;
        for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
            if (w_wr_idx == WW'(4 + i)) w_wr_op_sel[i] = 1'b1;
        end
        w_wr_ctrl  = (w_wr_idx == IDX_CTRL);
        w_wr_count = (w_wr_idx == IDX_COUNT);
        w_wr_err   = !(w_wr_ctrl || w_wr_count || (|w_wr_op_sel)) || w_busy;
        w_commit   = r_aw_held && r_w_held && !r_bvalid;
        w_wr_ok    = w_commit && !w_wr_err;
        w_start    = w_wr_ok && w_wr_ctrl && r_w_strb[0] && r_w_data[0];
    end

    // read mux for the address presented on AR
    always_comb begin
        w_rd_idx  = s0_axi_araddr[ADDR_WIDTH-1:2];
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_rd_idx)
            IDX_CTRL:   w_rd_data = DATA_WIDTH'({r_mode, 1'b0});
            IDX_STATUS: w_rd_data = DATA_WIDTH'({r_carry, r_done, w_busy});
            IDX_RESULT: w_rd_data = r_result;
            IDX_COUNT:  w_rd_data = DATA_WIDTH'(r_count);
            default: begin
                w_rd_err = 1'b1;
                for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
                    if (w_rd_idx == WW'(4 + i)) begin
                        w_rd_data = r_operand[i];
                        w_rd_err  = 1'b0;
                    end
                end
            end
        endcase
    end

    // one engine step: select operand k and fold it into the accumulator
    always_comb begin
        w_cur_op = '0;
        for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
            if (r_k == CW'(i)) w_cur_op = r_operand[i];
        end
        w_sum        = {1'b0, r_acc} + {1'b0, w_cur_op};
        w_diff       = {1'b0, r_acc} - {1'b0, w_cur_op};
        w_acc_next   = w_sum[DATA_WIDTH-1:0];
        w_carry_step = w_sum[DATA_WIDTH];
        if (r_run_mode == MODE_SUB) begin
            if (r_k == '0) begin
                w_acc_next   = w_cur_op;
                w_carry_step = 1'b0;
            end else begin
                w_acc_next   = w_diff[DATA_WIDTH-1:0];
                w_carry_step = w_diff[DATA_WIDTH];
            end
        end
        w_last = (r_k == r_n - CW'(1));
    end

    // engine state register
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) r_state <= S_IDLE;
        else               r_state <= w_state_next;
    end

    // engine next-state: START launches, the last operand step returns to idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_next = S_RUN;
            S_RUN:  if (w_last)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // engine datapath: latch mode/count on START, accumulate while running
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            r_acc      <= '0;
            r_result   <= '0;
            r_k        <= '0;
            r_n        <= '0;
            r_run_mode <= '0;
            r_done     <= 1'b0;
            r_carry    <= 1'b0;
        end else if (w_start) begin
            r_run_mode <= r_w_data[2:1];
            r_n        <= r_count;
            r_k        <= '0;
            r_done     <= 1'b0;
            r_carry    <= 1'b0;
            r_acc      <= (r_w_data[2:1] == MODE_ACC) ? r_result : '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= r_carry | w_carry_step;
            r_k     <= r_k + CW'(1);
            if (w_last) begin
                r_result <= w_acc_next;
                r_done   <= 1'b1;
            end
        end
    end

    // register file updates from committed, error-free writes
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            for (int unsigned i = 0; i < NUM_OPERANDS; i++) r_operand[i] <= '0;
            r_count <= CW'(NUM_OPERANDS);
            r_mode  <= '0;
        end else if (w_wr_ok) begin
            if (w_wr_ctrl && r_w_strb[0]) r_mode <= r_w_data[2:1];
            if (w_wr_count) r_count <= f_clamp(f_merge(DATA_WIDTH'(r_count), r_w_data, r_w_strb));
            for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
                if (w_wr_op_sel[i]) r_operand[i] <= f_merge(r_operand[i], r_w_data, r_w_strb);
            end
        end
    end

    // AW/W holders and write response; holders stay full until B is accepted
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OK;
        end else begin
            if (s0_axi_awvalid && s0_axi_awready) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s0_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (s0_axi_wvalid && s0_axi_wready) begin
                r_w_held <= 1'b1;
                r_w_data <= s0_axi_wdata;
                r_w_strb <= s0_axi_wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? RESP_ERR : RESP_OK;
            end
            if (r_bvalid && s0_axi_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // read channel: capture data on AR handshake, hold until R is accepted
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OK;
        end else if (s0_axi_arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_err ? RESP_ERR : RESP_OK;
        end else if (r_rvalid && s0_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_multi_adder.sv
// Randomised and directed checks of axil_multi_adder against a timestamped
// behavioural model of the register map and engine.
module tb_axil_multi_adder;

    localparam int unsigned NOP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axil_multi_adder #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (8),
        .NUM_OPERANDS (NOP)
    ) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_areset  (rst),
        .s0_axi_awaddr  (awaddr),
        .s0_axi_awvalid (awvalid),
        .s0_axi_awready (awready),
        .s0_axi_wdata   (wdata),
        .s0_axi_wstrb   (wstrb),
        .s0_axi_wvalid  (wvalid),
        .s0_axi_wready  (wready),
        .s0_axi_bresp   (bresp),
        .s0_axi_bvalid  (bvalid),
        .s0_axi_bready  (bready),
        .s0_axi_araddr  (araddr),
        .s0_axi_arvalid (arvalid),
        .s0_axi_arready (arready),
        .s0_axi_rdata   (rdata),
        .s0_axi_rresp   (rresp),
        .s0_axi_rvalid  (rvalid),
        .s0_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    // edge counter: after edge e (sampled #1 later) cyc_now == e
    int unsigned cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_op [NOP];
    int unsigned m_count;
    logic [1:0]  m_mode;
    logic [31:0] m_result;
    logic [31:0] m_old_result;
    bit          m_carry;
    bit          m_started;
    int unsigned m_start_edge;
    int unsigned m_n;

    task automatic m_reset();
        for (int i = 0; i < NOP; i++) m_op[i] = '0;
        m_count = NOP; m_mode = 2'b00; m_result = '0; m_old_result = '0;
        m_carry = 0; m_started = 0; m_start_edge = 0; m_n = 0;
    endtask

    // engine is busy in the state following edge e
    function automatic bit m_busy_at(input int unsigned e);
        return m_started && (e >= m_start_edge) && (e < m_start_edge + m_n);
    endfunction

    function automatic bit m_done_at(input int unsigned e);
        return m_started && (e >= m_start_edge + m_n);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] v;
        v = o;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = n[8*b +: 8];
        return v;
    endfunction

    task automatic m_launch(input logic [1:0] mode, input int unsigned ec);
        longint unsigned acc;
        bit c;
        c = 0;
        acc = (mode == 2'b10) ? longint'(m_result) : 0;
        for (int k = 0; k < int'(m_count); k++) begin
            if (mode == 2'b01) begin
                if (k == 0) acc = m_op[0];
                else begin
                    if (acc < m_op[k]) c = 1;
                    acc = (acc - m_op[k]) & 64'hFFFF_FFFF;
                end
            end else begin
                acc = acc + m_op[k];
                if (acc > 64'hFFFF_FFFF) begin c = 1; acc = acc & 64'hFFFF_FFFF; end
            end
        end
        m_old_result = m_result;
        m_result     = acc[31:0];
        m_carry      = c;
        m_start_edge = ec;
        m_n          = m_count;
        m_started    = 1;
    endtask

    // a write committing at edge ec sees the state after edge ec-1
    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned ec, output logic [1:0] r);
        int unsigned idx;
        logic [31:0] v;
        idx = a >> 2;
        r = 2'b00;
        if (m_busy_at(ec - 1) || !(idx == 0 || idx == 3 || (idx >= 4 && idx < 4 + NOP))) r = 2'b10;
        else if (idx == 0) begin
            if (s[0]) begin
                m_mode = d[2:1];
                if (d[0]) m_launch(d[2:1], ec);
            end
        end else if (idx == 3) begin
            v = merge(32'(m_count), d, s);
            if (v == 0) m_count = 1;
            else if (v > NOP) m_count = NOP;
            else m_count = v;
        end else m_op[idx-4] = merge(m_op[idx-4], d, s);
    endtask

    // a read captured at edge xe sees the state after edge xe-1; mk masks partial CARRY while busy
    task automatic m_read(input logic [7:0] a, input int unsigned xe,
                          output logic [31:0] d, output logic [1:0] r, output logic [31:0] mk);
        int unsigned idx, s;
        idx = a >> 2; s = xe - 1;
        d = '0; r = 2'b00; mk = '1;
        case (idx)
            0: d = {29'd0, m_mode, 1'b0};
            1: if (m_busy_at(s)) begin d = 32'h1; mk = 32'h3; end
               else d = {29'd0, m_carry, m_done_at(s), 1'b0};
            2: d = (m_started && s < m_start_edge + m_n) ? m_old_result : m_result;
            3: d = m_count;
            default: if (idx >= 4 && idx < 4 + NOP) d = m_op[idx-4];
                     else r = 2'b10;
        endcase
    endtask

    // ---------------- bus drivers (called #1 after an edge) ----------------
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output int unsigned ec, output bit tmo);
        bit aw_ok, w_ok, aw_hs, w_hs;
        int unsigned n;
        aw_ok = 0; w_ok = 0; n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while (!(aw_ok && w_ok) && n < 40) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1; n++;
            if (aw_hs) begin aw_ok = 1; awvalid = 0; end
            if (w_hs)  begin w_ok = 1;  wvalid = 0; end
        end
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        tmo = !bvalid; ec = cyc_now; r = bresp;
        @(posedge clk); #1;
        bready = 0; awvalid = 0; wvalid = 0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r,
                            output int unsigned xe, output bit tmo);
        bit hs, hs_now;
        int unsigned n;
        hs = 0; n = 0; xe = 0;
        araddr = a; arvalid = 1; rready = 1;
        while (!hs && n < 40) begin
            hs_now = arready;
            @(posedge clk); #1; n++;
            if (hs_now) begin hs = 1; xe = cyc_now; arvalid = 0; end
        end
        while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
        tmo = !rvalid; d = rdata; r = rresp;
        @(posedge clk); #1;
        rready = 0; arvalid = 0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag, output logic [1:0] r);
        logic [1:0] er;
        int unsigned ec;
        bit tmo;
        bus_write(a, d, s, r, ec, tmo);
        check({tag, "_wr_timeout"}, 32'(tmo), 32'd0);
        m_write(a, d, s, ec, er);
        if (!tmo) check({tag, "_bresp"}, 32'(r), 32'(er));
    endtask

    task automatic do_read(input logic [7:0] a, input string tag, output logic [31:0] obs);
        logic [31:0] d, ed, mk;
        logic [1:0]  r, er;
        int unsigned xe;
        bit tmo;
        bus_read(a, d, r, xe, tmo);
        check({tag, "_rd_timeout"}, 32'(tmo), 32'd0);
        if (!tmo) begin
            m_read(a, xe, ed, er, mk);
            check(tag, d & mk, ed & mk);
            check({tag, "_rresp"}, 32'(r), 32'(er));
        end
        obs = d;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        st = '0;
        for (int i = 0; i < 20; i++) begin
            do_read(8'h04, tag, st);
            if (!st[0]) break;
        end
        check({tag, "_idle"}, 32'(st[0]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] obs;
    logic [1:0]  resp;
    logic [7:0]  rd_addrs [12];
    int unsigned t5_ec;

    initial begin
        rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        m_reset();
        rd_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h15, 8'h1A, 8'h1F,
                     8'h20, 8'h7C, 8'h80, 8'hFC};

        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        rst = 0;
        for (int i = 0; i < 8; i++) do_read(8'(4 * i), "t1_reg", obs);

        // 2: sum of 1..4, polled at two phases to pin the busy window
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NOP; i++) do_write(8'(8'h10 + 4 * i), 32'(i + 1), 4'hF, "t2_op", resp);
            do_write(8'h00, 32'h1, 4'hF, "t2_start", resp);
            repeat (p) @(posedge clk);
            #0;
            wait_done("t2_status");
            do_read(8'h08, "t2_result", obs);
            check("t2_result_const", obs, 32'h0000_000A);
            do_read(8'h04, "t2_status_done", obs);
            check("t2_status_const", obs, 32'h2);
        end

        // 3: accumulate twice, then carry-out in sum mode
        for (int i = 0; i < 2; i++) begin
            do_write(8'h00, 32'h5, 4'hF, "t3_acc", resp);
            wait_done("t3_status");
            do_read(8'h08, "t3_result", obs);
        end
        do_write(8'h10, 32'hFFFF_FFFF, 4'hF, "t3_op0", resp);
        do_write(8'h14, 32'h1, 4'hF, "t3_op1", resp);
        do_write(8'h0C, 32'h2, 4'hF, "t3_count", resp);
        do_write(8'h00, 32'h1, 4'hF, "t3_start", resp);
        wait_done("t3_status_c");
        do_read(8'h08, "t3_wrap", obs);
        check("t3_wrap_const", obs, 32'h0);
        do_read(8'h04, "t3_carry", obs);
        check("t3_carry_const", obs, 32'h6);

        // 4: subtract with and without borrow
        do_write(8'h10, 32'd10, 4'hF, "t4_op0", resp);
        do_write(8'h14, 32'd3,  4'hF, "t4_op1", resp);
        do_write(8'h00, 32'h3,  4'hF, "t4_start", resp);
        wait_done("t4_status");
        do_read(8'h08, "t4_sub", obs);
        check("t4_sub_const", obs, 32'd7);
        do_write(8'h14, 32'd11, 4'hF, "t4_op1b", resp);
        do_write(8'h00, 32'h3,  4'hF, "t4_start_b", resp);
        wait_done("t4_status_b");
        do_read(8'h08, "t4_borrow", obs);
        check("t4_borrow_const", obs, 32'hFFFF_FFFF);
        do_read(8'h04, "t4_borrow_status", obs);

        // 5: W three cycles before AW, bready low for five cycles
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1; bready = 0;
        @(posedge clk); #1;
        wvalid = 0;
        check("t5_wready_held", 32'(wready), 32'd0);
        check("t5_awready_free", 32'(awready), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        awaddr = 8'h1C; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        check("t5_awready_held", 32'(awready), 32'd0);
        @(posedge clk); #1;
        t5_ec = cyc_now;
        check("t5_bvalid_rise", 32'(bvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t5_bvalid_hold", 32'(bvalid), 32'd1);
            check("t5_ready_low", 32'({awready, wready}), 32'd0);
            @(posedge clk); #1;
        end
        m_write(8'h1C, 32'h1234_5678, 4'hF, t5_ec, resp);
        check("t5_bresp", 32'(bresp), 32'(resp));
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("t5_bvalid_clr", 32'(bvalid), 32'd0);
        check("t5_ready_back", 32'({awready, wready}), 32'd3);
        repeat (2) begin @(posedge clk); #1; end
        check("t5_no_recommit", 32'(bvalid), 32'd0);
        do_read(8'h1C, "t5_op3", obs);

        // 6: errors and clamping
        do_write(8'h0C, 32'd4, 4'hF, "t6_count4", resp);
        do_write(8'h00, 32'h1, 4'hF, "t6_start", resp);
        do_write(8'h18, 32'hDEAD_BEEF, 4'hF, "t6_op2_busy", resp);
        check("t6_busy_slverr", 32'(resp), 32'h2);
        do_write(8'h00, 32'h1, 4'hF, "t6_start_busy", resp);
        wait_done("t6_status");
        do_read(8'h18, "t6_op2_kept", obs);
        do_write(8'h7C, 32'h1, 4'hF, "t6_wr_7c", resp);
        check("t6_7c_slverr", 32'(resp), 32'h2);
        do_write(8'h04, 32'h7, 4'hF, "t6_wr_status", resp);
        do_write(8'h08, 32'h7, 4'hF, "t6_wr_result", resp);
        do_read(8'h80, "t6_rd_80", obs);
        do_write(8'h0C, 32'd0, 4'hF, "t6_count0", resp);
        do_read(8'h0C, "t6_count_lo", obs);
        check("t6_count_lo_const", obs, 32'd1);
        do_write(8'h0C, 32'd9, 4'hF, "t6_count9", resp);
        do_read(8'h0C, "t6_count_hi", obs);
        check("t6_count_hi_const", obs, 32'd4);
        do_write(8'h10, 32'hAABB_CCDD, 4'b0101, "t6_strb_op", resp);
        do_read(8'h10, "t6_strb_op_rd", obs);
        do_write(8'h00, 32'h5, 4'b0000, "t6_ctrl_nostrb", resp);
        do_read(8'h04, "t6_no_start", obs);
        do_read(8'h00, "t6_ctrl_rd", obs);

        // reset in the middle of a run
        do_write(8'h00, 32'h1, 4'hF, "t7_start", resp);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_reset();
        check("t7_awready", 32'(awready), 32'd1);
        for (int i = 0; i < 5; i++) do_read(8'(4 * i), "t7_reg", obs);

        // randomised traffic
        for (int it = 0; it < 250; it++) begin
            int unsigned sel;
            logic [7:0]  a;
            logic [31:0] d;
            sel = $urandom_range(0, 11);
            if (sel <= 2) begin
                a = 8'(8'h10 + 4 * $urandom_range(0, NOP - 1) + $urandom_range(0, 3));
                d = $urandom;
                do_write(a, d, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, "rnd_op", resp);
            end else if (sel == 3) begin
                do_write(8'h0C, 32'($urandom_range(0, 6)), 4'hF, "rnd_count", resp);
            end else if (sel <= 5) begin
                d = {29'd0, 2'($urandom), 1'b1};
                do_write(8'h00, d, 4'hF, "rnd_start", resp);
            end else if (sel == 6) begin
                a = rd_addrs[$urandom_range(8, 11)];
                do_write(a, $urandom, 4'hF, "rnd_badwr", resp);
            end else if (sel <= 10) begin
                do_read(rd_addrs[$urandom_range(0, 11)], "rnd_rd", obs);
            end else begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
        end
        wait_done("rnd_final");
        do_read(8'h08, "rnd_final_result", obs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
